// File: rtl/msg_pkg.sv
// msg_pkg: shared types and constants for the message sequencer.
// State encodings, glyph geometry and the three fixed overlay strings.
package msg_pkg;

    // State encoding doubles as arbitration rank: a larger value wins.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BOARD   = 2'd1,
        ST_READY   = 2'd2,
        ST_TIMESUP = 2'd3
    } state_e;

    typedef logic [4:0] code_t;

    // Pending-flag bit positions
    localparam int P_BOARD   = 0;
    localparam int P_READY   = 1;
    localparam int P_TIMESUP = 2;

    localparam code_t BLANK     = 5'd31;
    localparam int    GLYPH_W   = 50;
    localparam int    GLYPH_H   = 50;
    localparam int    GLYPH_SZ  = 2500;
    localparam int    NUM_SLOTS = 10;
    localparam int    WIN_W     = GLYPH_W * NUM_SLOTS;

    // "GET READY"
    localparam code_t STR_READY [NUM_SLOTS] = '{
        5'd6, 5'd4, 5'd19, BLANK, 5'd17, 5'd4, 5'd0, 5'd3, 5'd24, BLANK};
    // "TIME IS UP"
    localparam code_t STR_TIMESUP [NUM_SLOTS] = '{
        5'd19, 5'd8, 5'd12, 5'd4, BLANK, 5'd8, 5'd18, BLANK, 5'd20, 5'd15};
    // "HOUSE CUP"
    localparam code_t STR_BOARD [NUM_SLOTS] = '{
        5'd7, 5'd14, 5'd20, 5'd18, 5'd4, BLANK, 5'd2, 5'd20, 5'd15, BLANK};

endpackage

// File: rtl/glyph_addr_gen.sv
// glyph_addr_gen: tracks the pixel/slot position inside the text window and
// produces the registered glyph ROM address and glyph_on flag.
module glyph_addr_gen import msg_pkg::*; #(
    parameter int COL0 = 120,
    parameter int ROW0 = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [8:0]  row_i,
    input  logic [9:0]  col_i,
    input  code_t       code_i,
    input  logic        hide_i,
    output logic [3:0]  slot_o,
    output logic [15:0] rom_addr_o,
    output logic        glyph_on_o
);

    logic [9:0]  row_off;
    logic [10:0] col_off;
    logic        in_win, lit;
    logic [5:0]  px_q, px_d, px_cur;
    logic [3:0]  slot_q, slot_d, slot_cur;
    logic [15:0] addr_q, addr_d;
    logic        on_q, on_d;

    // Offsets wrap to large values when left of / above the window, so a
    // single upper-bound compare covers both sides.
    assign row_off  = 10'(row_i) - 10'(ROW0);
    assign col_off  = 11'(col_i) - 11'(COL0);
    assign in_win   = (row_off < 10'(GLYPH_H)) && (col_off < 11'(WIN_W));
    assign px_cur   = (col_off == 11'd0) ? 6'd0 : px_q;
    assign slot_cur = (col_off == 11'd0) ? 4'd0 : slot_q;
    assign slot_o   = slot_cur;
    assign lit      = in_win && (code_i != BLANK);

    // Next pixel position and address for the pixel currently on row/col
    always_comb begin
        px_d   = px_cur;
        slot_d = slot_cur;
        if (in_win) begin
            if (px_cur == 6'(GLYPH_W - 1)) begin
                px_d   = 6'd0;
                slot_d = slot_cur + 4'd1;
            end else begin
                px_d = px_cur + 6'd1;
            end
        end
        addr_d = 16'd0;
        if (lit)
            addr_d = 16'(code_i) * 16'(GLYPH_SZ) + 16'(row_off) * 16'(GLYPH_W) + 16'(px_cur);
        on_d = lit && !hide_i;
    end

    // Position counters and one-cycle address pipeline
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            px_q   <= '0;
            slot_q <= '0;
            addr_q <= '0;
            on_q   <= 1'b0;
        end else begin
            px_q   <= px_d;
            slot_q <= slot_d;
            addr_q <= addr_d;
            on_q   <= on_d;
        end
    end

    assign rom_addr_o = addr_q;
    assign glyph_on_o = on_q;

endmodule

// File: rtl/msg_sequencer.sv
// msg_sequencer: arbitrates overlay message requests, holds each for a
// frame-counted period and drives the glyph ROM address.
// Optional macro MSG_SEQ_BLINK_EN: blinks times-up every 8 frames.
module msg_sequencer import msg_pkg::*; #(
    parameter int COL0           = 120,
    parameter int ROW0           = 0,
    parameter int READY_FRAMES   = 120,
    parameter int TIMESUP_FRAMES = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        req_ready,
    input  logic        req_times_up,
    input  logic        req_board,
    output logic        get_ready,
    output logic        times_up,
    output logic        leaderboard,
    output logic        busy,
    output logic [15:0] rom_addr,
    output logic        glyph_on
);

    state_e     state_q, state_d, top_st;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] pend_q, pend_d, pend_eff;
    logic       expire;
    logic       gr_q, tu_q, lb_q, busy_q;
    logic [3:0] slot;
    code_t      code;
    logic       hide;

    // Arbitration and hold-counter next state; requests in the frame_start
    // cycle are already eligible via pend_eff.
    always_comb begin
        pend_eff = pend_q;
        pend_eff[P_BOARD]   = pend_q[P_BOARD]   | req_board;
        pend_eff[P_READY]   = pend_q[P_READY]   | req_ready;
        pend_eff[P_TIMESUP] = pend_q[P_TIMESUP] | req_times_up;

        if (pend_eff[P_TIMESUP])    top_st = ST_TIMESUP;
        else if (pend_eff[P_READY]) top_st = ST_READY;
        else if (pend_eff[P_BOARD]) top_st = ST_BOARD;
        else                        top_st = ST_IDLE;

        expire = ((state_q == ST_READY)   && (cnt_q == 8'(READY_FRAMES - 1))) ||
                 ((state_q == ST_TIMESUP) && (cnt_q == 8'(TIMESUP_FRAMES - 1)));

        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_eff;
        if (frame_start) begin
            // Equal rank re-enters the active state, restarting its count
            if (top_st != ST_IDLE && (top_st >= state_q || expire)) begin
                state_d = top_st;
                cnt_d   = 8'd0;
                case (top_st)
                    ST_TIMESUP: pend_d[P_TIMESUP] = 1'b0;
                    ST_READY:   pend_d[P_READY]   = 1'b0;
                    default:    pend_d[P_BOARD]   = 1'b0;
                endcase
            end else if (expire) begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end else if (state_q == ST_READY || state_q == ST_TIMESUP) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Sequencer state with registered mode and busy outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            gr_q    <= 1'b0;
            tu_q    <= 1'b0;
            lb_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            gr_q    <= (state_d == ST_READY);
            tu_q    <= (state_d == ST_TIMESUP);
            lb_q    <= (state_d == ST_BOARD);
            busy_q  <= (state_d != ST_IDLE) || (|pend_d);
        end
    end

    // Glyph code of the active string at the current slot; IDLE shows blanks
    always_comb begin
        code = BLANK;
        if (slot < 4'(NUM_SLOTS)) begin
            case (state_q)
                ST_READY:   code = STR_READY[slot];
                ST_TIMESUP: code = STR_TIMESUP[slot];
                ST_BOARD:   code = STR_BOARD[slot];
                default:    code = BLANK;
            endcase
        end
    end

`ifdef MSG_SEQ_BLINK_EN
    assign hide = (state_q == ST_TIMESUP) && cnt_q[3];
`else
    assign hide = 1'b0;
`endif

    glyph_addr_gen #(.COL0(COL0), .ROW0(ROW0)) u_addr (
        .clk_i      (clk),
        .reset_i    (reset),
        .row_i      (row),
        .col_i      (col),
        .code_i     (code),
        .hide_i     (hide),
        .slot_o     (slot),
        .rom_addr_o (rom_addr),
        .glyph_on_o (glyph_on)
    );

    assign get_ready   = gr_q;
    assign times_up    = tu_q;
    assign leaderboard = lb_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// tb_msg_sequencer: directed table vectors plus hand sequences for the
// multi-frame hold, preemption, address and reset corner cases.
module tb_msg_sequencer;

    localparam int COL0 = 120;

    logic        clk = 1'b0;
    logic        reset = 1'b0, frame_start = 1'b0;
    logic [8:0]  row = '0;
    logic [9:0]  col = '0;
    logic        req_ready = 1'b0, req_times_up = 1'b0, req_board = 1'b0;
    logic        get_ready, times_up, leaderboard, busy, glyph_on;
    logic [15:0] rom_addr;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MSG_SEQ_BLINK_EN
    localparam logic BLINK_ON = 1'b1;
`else
    localparam logic BLINK_ON = 1'b0;
`endif

    msg_sequencer #(.COL0(COL0), .ROW0(0), .READY_FRAMES(120), .TIMESUP_FRAMES(180)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .row(row), .col(col),
        .req_ready(req_ready), .req_times_up(req_times_up), .req_board(req_board),
        .get_ready(get_ready), .times_up(times_up), .leaderboard(leaderboard),
        .busy(busy), .rom_addr(rom_addr), .glyph_on(glyph_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, fs, rr, rt, rb;
        logic [3:0] exp;   // {get_ready, times_up, leaderboard, busy}
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] modes();
        return {get_ready, times_up, leaderboard, busy};
    endfunction

    task automatic do_reset();
        reset = 1'b1; frame_start = 1'b0;
        req_ready = 1'b0; req_times_up = 1'b0; req_board = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1; tick();
        frame_start = 1'b0; tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_req(input logic rr, input logic rt, input logic rb);
        req_ready = rr; req_times_up = rt; req_board = rb; tick();
        req_ready = 1'b0; req_times_up = 1'b0; req_board = 1'b0;
    endtask

    initial begin
        //                rst  fs   rr   rt   rb   {gr,tu,lb,busy}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001}; // busy from pending
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011}; // enter BOARD
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011}; // no mid-frame change
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001}; // ready preempts
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1001};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001}; // board can't preempt
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001}; // restart
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0101}; // req with fs
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000}; // req with reset dropped
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}; // board flag gone
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001}; // READY next edge
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}; // reset mid-READY

        do_reset();
        chk("reset_modes", 32'(modes()), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_glyph_on", 32'(glyph_on), 32'd0);

        for (int i = 0; i < 16; i++) begin
            reset = vecs[i].rst; frame_start = vecs[i].fs;
            req_ready = vecs[i].rr; req_times_up = vecs[i].rt; req_board = vecs[i].rb;
            tick();
            chk($sformatf("vec%0d_modes", i), 32'(modes()), 32'(vecs[i].exp));
        end
        reset = 1'b0; frame_start = 1'b0;
        req_ready = 1'b0; req_times_up = 1'b0; req_board = 1'b0;

        // Get-ready hold: 120 frames then IDLE
        do_reset();
        pulse_req(1'b1, 1'b0, 1'b0);
        chk("hold_busy_pending", 32'(modes()), 32'b0001);
        frame();
        chk("hold_frame1", 32'(modes()), 32'b1001);
        frames(119);
        chk("hold_frame120", 32'(modes()), 32'b1001);
        frame();
        chk("hold_frame121_idle", 32'(modes()), 32'b0000);

        // Preemption of the board by times-up, then 180-frame hold
        do_reset();
        pulse_req(1'b0, 1'b0, 1'b1);
        frames(5);
        chk("preempt_board", 32'(modes()), 32'b0011);
        pulse_req(1'b0, 1'b1, 1'b0);
        chk("preempt_wait_frame", 32'(modes()), 32'b0011);
        frame();
        chk("preempt_frame6", 32'(modes()), 32'b0101);
        frames(179);
        chk("timesup_frame185", 32'(modes()), 32'b0101);
        frame();
        chk("timesup_done_idle", 32'(modes()), 32'b0000);

        // Address generation in READY
        do_reset();
        pulse_req(1'b1, 1'b0, 1'b0);
        frame();
        row = 9'd10;
        for (int k = 0; k <= 150; k++) begin
            col = 10'(COL0 + k);
            tick();
            if (k == 0) chk("addr_slot0_G", 32'(rom_addr), 32'd15500);
            if (k == 57) begin
                chk("addr_slot1_E", 32'(rom_addr), 32'd10507);
                chk("on_slot1_E", 32'(glyph_on), 32'd1);
            end
            if (k == 150) begin
                chk("addr_slot3_blank", 32'(rom_addr), 32'd0);
                chk("on_slot3_blank", 32'(glyph_on), 32'd0);
            end
        end
        col = 10'(COL0 - 1); tick();
        chk("on_left_of_window", 32'(glyph_on), 32'd0);
        row = 9'd50; col = 10'(COL0); tick();
        chk("addr_below_window", 32'(rom_addr), 32'd0);
        chk("on_below_window", 32'(glyph_on), 32'd0);
        row = 9'd0; col = 10'd0;

        // IDLE shows nothing even on window pixels
        do_reset();
        row = 9'd10; col = 10'(COL0); tick();
        chk("idle_on", 32'(glyph_on), 32'd0);
        chk("idle_addr", 32'(rom_addr), 32'd0);

        // TIMESUP addresses, blink phases and reset mid-message
        do_reset();
        pulse_req(1'b0, 1'b1, 1'b0);
        frames(4);   // counter now 3
        row = 9'd49;
        for (int k = 0; k <= 499; k++) begin
            col = 10'(COL0 + k);
            tick();
            if (k == 0) chk("addr_tu_T_last_row", 32'(rom_addr), 32'd49950);
            if (k == 499) begin
                chk("addr_tu_P_corner", 32'(rom_addr), 32'd39999);
                chk("on_tu_P_corner", 32'(glyph_on), 32'd1);
            end
        end
        row = 9'd10; col = 10'(COL0); tick();
        chk("blink_cnt3_on", 32'(glyph_on), 32'd1);
        frames(5);   // counter 8
        col = 10'(COL0); tick();
        chk("blink_cnt8_on", 32'(glyph_on), 32'(!BLINK_ON));
        chk("blink_cnt8_addr", 32'(rom_addr), 32'd48000);
        frames(8);   // counter 16
        col = 10'(COL0); tick();
        chk("blink_cnt16_on", 32'(glyph_on), 32'd1);
        reset = 1'b1; tick();
        chk("midmsg_reset_modes", 32'(modes()), 32'd0);
        chk("midmsg_reset_addr", 32'(rom_addr), 32'd0);
        chk("midmsg_reset_on", 32'(glyph_on), 32'd0);
        reset = 1'b0; col = 10'd0; row = 9'd0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
